fanin_rr_merge: RTL and testbench

- Merges NUM_IN ready/valid token streams into one output stream with round-robin arbitration.
- It is the fan-in counterpart of the fanout ready-combine logic on the same stream interface; it sits at PE/MEM tile inputs where several upstream producers feed one consumer.
- A grant can be locked for a whole packet, ending on a stop token, so streams are not interleaved mid-packet.
- A 2-entry output FIFO decouples in_ready from out_ready.

---
 rtl/fanin_pkg.sv | 8 +
 rtl/fanin_out_fifo.sv | 33 +++
 rtl/fanin_rr_merge.sv | 74 +++++++
 tb/tb_fanin_rr_merge.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fanin_pkg.sv
// fanin_pkg: shared widths and types for the round-robin fan-in merge
package fanin_pkg;
  localparam int NUM_IN_DEF = 4;
  localparam int DATA_WIDTH_DEF = 17;
  localparam int STOP_BIT = DATA_WIDTH_DEF - 1;
  typedef logic [DATA_WIDTH_DEF-1:0] token_t;
  typedef logic [$clog2(NUM_IN_DEF)-1:0] src_idx_t;
endpackage

// File: rtl/fanin_out_fifo.sv
// fanin_out_fifo: two-entry output FIFO of {src, token}; the head holds its last value when empty
module fanin_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    head_d = (pop_i && cnt_q == 2'd2) ? tail_q
           : (push_i && (cnt_q == 2'd0 || pop_i)) ? din_i : head_q;
    tail_d = (push_i && cnt_q == 2'd1 && !pop_i) ? din_i : tail_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  assign dout_o = head_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/fanin_rr_merge.sv
// fanin_rr_merge: round-robin merge of NUM_IN ready/valid streams with optional per-packet grant lock
module fanin_rr_merge
  import fanin_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit LOCK_ON_PKT = 1'b1,
  localparam int SW = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            in_en,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SW-1:0]                out_src
);
  logic [NUM_IN-1:0] req;
  logic [SW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, gnt;
  logic run_q, lock_q, lock_d, lock_eff, gnt_vld, acc, pop;
  logic [1:0] cnt;
  logic [DATA_WIDTH-1:0] tok;
  assign req = in_en & in_valid;
  assign lock_eff = lock_q & in_en[lock_idx_q];
  // Descending scan so the requester closest to rr_q wins; an active lock overrides it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    for (int k = NUM_IN - 1; k >= 0; k--)
      if (req[SW'((int'(rr_q) + k) % NUM_IN)]) begin
        gnt_vld = 1'b1;
        gnt = SW'((int'(rr_q) + k) % NUM_IN);
      end
    if (lock_eff) begin
      gnt_vld = req[lock_idx_q];
      gnt = lock_idx_q;
    end
  end
  // run_q keeps every in_ready low while reset is held without routing rst_n into logic.
  assign in_ready = (run_q && gnt_vld && cnt != 2'd2) ? NUM_IN'(1) << gnt : '0;
  assign acc = |(in_ready & in_valid);
  assign tok = in_data[int'(gnt) * DATA_WIDTH +: DATA_WIDTH];
  assign out_valid = cnt != 2'd0;
  assign pop = out_valid & out_ready;
  always_comb begin
    rr_d = acc ? SW'((int'(gnt) + 1) % NUM_IN) : rr_q;
    lock_d = acc ? (LOCK_ON_PKT && !tok[DATA_WIDTH-1]) : lock_eff;
    lock_idx_d = acc ? gnt : lock_idx_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q      <= 1'b0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      run_q      <= 1'b1;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  fanin_out_fifo #(.W(SW + DATA_WIDTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (acc),
    .pop_i  (pop),
    .din_i  ({gnt, tok}),
    .dout_o ({out_src, out_data}),
    .cnt_o  (cnt)
  );
endmodule

// File: tb/tb_fanin_rr_merge.sv
// tb_fanin_rr_merge: directed scoreboard bench for the round-robin fan-in merge
module tb_fanin_rr_merge;
  import fanin_pkg::*;
  localparam int N = NUM_IN_DEF;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int SW = $clog2(N);
  typedef logic [SW+DW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] en, valid, rdy;
  logic [N*DW-1:0] data;
  logic [DW-1:0] out_data;
  logic out_valid, out_ready;
  logic [SW-1:0] out_src;

  logic [N-1:0] b_en, b_valid, b_rdy;
  logic [N*DW-1:0] b_data;
  logic [DW-1:0] b_out_data;
  logic b_out_valid, b_out_ready;
  logic [SW-1:0] b_out_src;

  int checks = 0;
  int errors = 0;
  ent_t sb[$];

  fanin_rr_merge #(.LOCK_ON_PKT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_en(en), .in_valid(valid), .in_data(data),
    .in_ready(rdy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src)
  );

  fanin_rr_merge #(.LOCK_ON_PKT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_en(b_en), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_rdy), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_src(b_out_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int i, input token_t d);
    valid[i] = 1'b1;
    data[i*DW +: DW] = d;
  endtask

  task automatic step(input string tag, input logic [N-1:0] exp_rdy, input int exp_ov);
    @(negedge clk);
    check(tag, 32'(rdy), 32'(exp_rdy));
    if (exp_ov >= 0) check({tag, "_ov"}, 32'(out_valid), 32'(exp_ov));
    for (int i = 0; i < N; i++)
      if (exp_rdy[i] && valid[i]) sb.push_back({SW'(i), data[i*DW +: DW]});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e[DW-1:0]));
        check("out_src", 32'(out_src), 32'(e[SW+DW-1:DW]));
      end
    end
  end

  initial begin
    en = '1; valid = '1; data = '0; out_ready = 1'b1;
    b_en = '0; b_valid = '0; b_data = '0; b_out_ready = 1'b0;
    @(negedge clk);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_src", 32'(out_src), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_rdy_b", 32'(b_rdy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid = '0;
    @(posedge clk); #1;

    b_en = '1; b_valid = '1; b_out_ready = 1'b1;
    for (int i = 0; i < N; i++) b_data[i*DW +: DW] = DW'(32'h100 + i);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(b_rdy), 32'(1) << (k % N));
      if (k > 0) begin
        check("rr_ov", 32'(b_out_valid), 32'd1);
        check("rr_src", 32'(b_out_src), 32'((k - 1) % N));
        check("rr_data", 32'(b_out_data), 32'h100 + 32'((k - 1) % N));
      end
      @(posedge clk); #1;
    end
    b_valid = '0;

    en = 4'b0001;
    set_in(0, 17'h00005); step("single0", 4'b0001, 0);
    set_in(0, 17'h00006); step("single1", 4'b0001, 1);
    set_in(0, 17'h10000); step("single2", 4'b0001, 1);
    valid[0] = 1'b0;      step("single_idle", 4'b0000, 1);
    step("single_empty", 4'b0000, 0);

    en = '1;
    set_in(1, 17'h00011); set_in(2, 17'h10022); step("lock0", 4'b0010, -1);
    set_in(1, 17'h00012); step("lock1", 4'b0010, -1);
    set_in(1, 17'h10000); step("lock2", 4'b0010, -1);
    valid[1] = 1'b0;      step("lock_rel", 4'b0100, -1);
    valid[2] = 1'b0;      step("lock_idle", 4'b0000, 1);
    step("lock_empty", 4'b0000, 0);

    out_ready = 1'b0;
    set_in(3, 17'h10033); step("bp0", 4'b1000, 0);
    valid[3] = 1'b0; set_in(0, 17'h10040); step("bp1", 4'b0001, 1);
    valid[0] = 1'b0; set_in(1, 17'h10050); step("bp_full", 4'b0000, 1);
    out_ready = 1'b1; step("bp_pop", 4'b0000, 1);
    step("bp_reassert", 4'b0010, 1);
    valid[1] = 1'b0; step("bp_d0", 4'b0000, 1);
    step("bp_d1", 4'b0000, 0);

    set_in(3, 17'h00033); step("abort_lock", 4'b1000, -1);
    set_in(3, 17'h00034); set_in(0, 17'h10040); set_in(2, 17'h10042);
    step("abort_hold", 4'b1000, -1);
    en[3] = 1'b0;     step("abort_rr", 4'b0001, -1);
    valid[0] = 1'b0;  step("abort_next", 4'b0100, -1);
    valid[2] = 1'b0;  step("abort_none", 4'b0000, -1);
    valid[3] = 1'b0; en = '1; step("abort_drain", 4'b0000, -1);
    step("abort_empty", 4'b0000, 0);

    out_ready = 1'b0;
    set_in(1, 17'h00061); step("mrst_a", 4'b0010, -1);
    set_in(1, 17'h00062); step("mrst_b", 4'b0010, -1);
    step("mrst_full", 4'b0000, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_rdy", 32'(rdy), 32'd0);
    check("mrst_data", 32'(out_data), 32'd0);
    sb.delete();
    set_in(0, 17'h10070); set_in(1, 17'h10071); out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step("post_rst0", 4'b0001, 0);
    valid[0] = 1'b0; step("post_rst1", 4'b0010, 1);
    valid[1] = 1'b0; step("post_d0", 4'b0000, 1);
    step("post_d1", 4'b0000, 0);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
